// File: rtl/friscv_issue_queue.sv
// In-order, first-word-fall-through issue queue between the control unit and the processing stage.
// Words always spend at least one cycle in storage. A flush discards everything queued.
`ifndef INST_BUS_W
`define INST_BUS_W 32
`endif

module friscv_issue_queue #(
  parameter int INST_BUS_W = `INST_BUS_W,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  flush,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [INST_BUS_W-1:0] i_instbus,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [INST_BUS_W-1:0] o_instbus,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [INST_BUS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  push;
  logic                  pop;

  // The MSB of each pointer is a wrap bit, which tells full apart from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  // i_ready and o_valid depend only on state and flush. No input-to-output path exists.
  assign i_ready   = !full && !flush;
  assign o_valid   = !empty && !flush;
  assign o_instbus = mem[rd_ptr[ADDR_W-1:0]];
  assign count     = count_q;
  assign busy      = !empty || i_valid;

  assign push = i_valid && i_ready;
  assign pop  = o_valid && o_ready;

  // NOTE: storage has no reset. The pointers alone decide which entries are live, so resetting
  // the array would only add reset fan-out and stop it from mapping onto RAM.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= i_instbus;
    end
  end

  // NOTE: all state here uses non-blocking assignments. Each register then updates from values
  // sampled before the edge, whatever the order of the statements.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (srst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_issue_queue.sv
// Directed bench for friscv_issue_queue with DEPTH = 4, followed by a randomised run checked against a queue model.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_friscv_issue_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             srst;
  logic             flush;
  logic             i_valid;
  logic             i_ready;
  logic [W-1:0]     i_instbus;
  logic             o_valid;
  logic             o_ready;
  logic [W-1:0]     o_instbus;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             busy;

  int vectors    = 0;
  int miscompares = 0;

  friscv_issue_queue #(.INST_BUS_W(W), .DEPTH(DEPTH)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .flush     (flush),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_instbus (i_instbus),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_instbus (o_instbus),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  logic [W-1:0] model [$];
  logic         exp_ready;
  logic         exp_valid;

  initial begin
    aresetn = 1'b0; srst = 1'b0; flush = 1'b0;
    i_valid = 1'b1; o_ready = 1'b0; i_instbus = '0;

    // Reset held for five cycles with a word on offer.
    repeat (5) step();
    check("rst_i_ready", W'(i_ready), 1);
    check("rst_o_valid", W'(o_valid), 0);
    check("rst_count",   W'(count),   0);
    check("rst_empty",   W'(empty),   1);
    check("rst_full",    W'(full),    0);
    check("rst_busy",    W'(busy),    1);
    aresetn = 1'b1;
    i_valid = 1'b0;
    #1;
    check("idle_busy", W'(busy), 0);
    step();

    // Fill with o_ready low, offer a fifth word, then drain.
    for (int k = 0; k < 4; k++) begin
      i_valid   = 1'b1;
      i_instbus = W'((k + 1) * 'h11);
      #1;
      check("fill_i_ready", W'(i_ready), 1);
      step();
    end
    i_instbus = 'h55;
    #1;
    check("fill_full",    W'(full),    1);
    check("fill_i_ready", W'(i_ready), 0);
    check("fill_count",   W'(count),   4);
    step();
    check("fill_no5th_count", W'(count), 4);
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_valid", W'(o_valid), 1);
      check("drain_data",  o_instbus, W'((k + 1) * 'h11));
      step();
    end
    check("drain_empty", W'(empty),   1);
    check("drain_valid", W'(o_valid), 0);

    // Sixteen back-to-back words with o_ready high; the pointers wrap twice.
    for (int k = 0; k < 16; k++) begin
      i_valid   = 1'b1;
      i_instbus = W'('h100 + k);
      #1;
      if (k > 0) begin
        check("stream_valid", W'(o_valid), 1);
        check("stream_data",  o_instbus, W'('h100 + k - 1));
        check("stream_count", W'(count),  1);
      end
      step();
    end
    i_valid = 1'b0;
    #1;
    check("stream_last", o_instbus, 'h10F);
    step();
    check("stream_empty", W'(empty), 1);

    // Simultaneous push and pop at count 3, then a pop with a word offered while full.
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_instbus = W'('hA0 + k);
      step();
    end
    check("pp_count3", W'(count), 3);
    o_ready = 1'b1;
    for (int k = 3; k < 5; k++) begin
      i_instbus = W'('hA0 + k);
      #1;
      check("pp_head", o_instbus, W'('hA0 + k - 3));
      step();
      check("pp_count", W'(count), 3);
    end
    o_ready = 1'b0; i_instbus = 'hA5;
    step();
    check("pp_full", W'(full), 1);
    o_ready = 1'b1; i_instbus = 'hEE;
    #1;
    check("pp_full_i_ready", W'(i_ready), 0);
    step();
    check("pp_full_pop_count", W'(count), 3);
    i_valid = 1'b0;
    for (int k = 3; k < 6; k++) begin
      #1;
      check("pp_drain", o_instbus, W'('hA0 + k));
      step();
    end
    check("pp_empty", W'(empty), 1);

    // Flush with three entries queued and both sides willing.
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_instbus = W'('hC0 + k);
      step();
    end
    i_instbus = 'hDD; o_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_i_ready", W'(i_ready), 0);
    check("flush_o_valid", W'(o_valid), 0);
    step();
    flush = 1'b0; i_valid = 1'b0;
    #1;
    check("post_flush_count", W'(count),   0);
    check("post_flush_empty", W'(empty),   1);
    check("post_flush_valid", W'(o_valid), 0);
    check("post_flush_ready", W'(i_ready), 1);
    i_valid = 1'b1; i_instbus = 'hAB;
    #1;
    check("no_bypass", W'(o_valid), 0);
    step();
    i_valid = 1'b0;
    #1;
    check("ab_valid", W'(o_valid), 1);
    check("ab_data",  o_instbus, 'hAB);
    step();
    check("ab_empty", W'(empty), 1);

    // Synchronous reset, then asynchronous reset asserted between edges.
    o_ready = 1'b0;
    i_valid = 1'b1; i_instbus = 'h77;
    step(); step();
    i_valid = 1'b0; srst = 1'b1;
    step();
    srst = 1'b0;
    check("srst_count", W'(count), 0);
    check("srst_empty", W'(empty), 1);
    i_valid = 1'b1;
    step(); step();
    i_valid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_count",   W'(count),   0);
    check("arst_o_valid", W'(o_valid), 0);
    check("arst_i_ready", W'(i_ready), 1);
    step();
    aresetn = 1'b1;
    step();

    // Randomised traffic against a queue model; flush is asserted about 5% of the time.
    model.delete();
    for (int c = 0; c < 3000; c++) begin
      i_valid   = 1'($urandom_range(0, 1));
      o_ready   = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 99) < 5);
      i_instbus = $urandom;
      exp_ready = (model.size() < DEPTH) && !flush;
      exp_valid = (model.size() != 0) && !flush;
      #1;
      check("rnd_count",   W'(count),   W'(model.size()));
      check("rnd_i_ready", W'(i_ready), W'(exp_ready));
      check("rnd_o_valid", W'(o_valid), W'(exp_valid));
      if (exp_valid) check("rnd_data", o_instbus, model[0]);
      if (flush) begin
        model.delete();
      end else begin
        if (exp_valid && o_ready) void'(model.pop_front());
        if (exp_ready && i_valid) model.push_back(i_instbus);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
